// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable irq.
// Registers: CTRL (0x0), PRESET (0x4), COUNT (0x8, read-only); reads are combinational.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic w_hit;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic w_reload;
  logic w_expire;
  logic w_flag_clr;
  logic w_unused;

  assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ctrl   = we && w_hit && (addr[3:2] == 2'd0);
  assign w_wr_preset = we && w_hit && (addr[3:2] == 2'd1);
  assign w_en        = r_ctrl[0];
  // MODE 10/11 fall back to one-shot, so only 01 selects reload.
  assign w_reload    = (r_ctrl[2:1] == 2'b01);
  // COUNT of 0 or 1 both expire, which makes PRESET = 0 act like PRESET = 1.
  assign w_expire    = (r_state == S_CNT) && w_en && (r_count <= 32'd1);
  assign w_flag_clr  = w_wr_ctrl || w_wr_preset || ((r_state == S_INT) && w_reload);
  assign w_unused    = &{1'b0, addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_en) r_state <= S_LOAD;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count <= '0;
            r_state <= S_INT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= wdata[3:0];
    end else if ((r_state == S_INT) && !w_reload) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= wdata;
    end
  end

  // Expiry beats a software clear landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_flag <= 1'b0;
    end else if (w_expire) begin
      r_irq_flag <= 1'b1;
    end else if (w_flag_clr) begin
      r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, r_ctrl};
        2'd1:    rdata = r_preset;
        2'd2:    rdata = r_count;
        default: rdata = '0;
      endcase
    end
  end

  assign irq = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus randomized register traffic,
// every cycle compared against a behavioural model of the timer.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model, stepped once per rising edge with the inputs seen at that edge.
  typedef enum {PH_IDLE, PH_LOAD, PH_COUNT, PH_INT} phase_t;
  phase_t      m_ph;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;

  task automatic model_reset();
    m_ph = PH_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic        hit, wc, wp, fire, drop;
    logic [3:0]  nc;
    logic [31:0] np, nn;
    phase_t      nph;
    hit  = we && (addr[31:4] == BASE[31:4]);
    wc   = hit && (addr[3:2] == 2'd0);
    wp   = hit && (addr[3:2] == 2'd1);
    nc   = m_ctrl; np = m_preset; nn = m_count; nph = m_ph;
    fire = 1'b0; drop = 1'b0;
    case (m_ph)
      PH_IDLE:  if (m_ctrl[0]) nph = PH_LOAD;
      PH_LOAD:  begin nn = m_preset; nph = PH_COUNT; end
      PH_COUNT: begin
        if (!m_ctrl[0]) nph = PH_IDLE;
        else if (m_count >= 2) nn = m_count - 1;
        else begin nn = 0; fire = 1'b1; nph = PH_INT; end
      end
      PH_INT: begin
        if (m_ctrl[2:1] == 2'b01) drop = 1'b1;
        else nc[0] = 1'b0;
        nph = PH_IDLE;
      end
    endcase
    if (wc) nc = wdata[3:0];
    if (wp) np = wdata;
    if (fire) m_flag = 1'b1;
    else if (wc || wp || drop) m_flag = 1'b0;
    m_ctrl = nc; m_preset = np; m_count = nn; m_ph = nph;
  endtask

  task automatic check_all(input string tag);
    for (int unsigned k = 0; k < 3; k++) begin
      addr = BASE + 32'(k * 4);
      #1;
      check_val($sformatf("%s_r%0d", tag, k * 4), rdata, model_read(addr));
    end
    check_val($sformatf("%s_irq", tag), {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    we = 1'b0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] data);
    addr = BASE + off; wdata = data; we = 1'b1;
    tick(tag);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] v);
    addr = BASE + off;
    #1;
    v = rdata;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    we = 1'b0; addr = BASE; wdata = '0; reset = 1'b1;
    model_reset();
    check_all("por");
    reset = 1'b0;

    // Register readback and read-only COUNT
    wr("t1", 32'h4, 32'd5);
    rd(32'h4, v); check_val("t1_preset", v, 32'd5);
    rd(32'h0, v); check_val("t1_ctrl", v, 32'd0);
    wr("t1", 32'h8, 32'h1234);
    rd(32'h8, v); check_val("t1_count_ro", v, 32'd0);

    // One-shot, PRESET = 3
    wr("t2", 32'h4, 32'd3);
    wr("t2", 32'h0, 32'h9);
    for (int e = 1; e <= 7; e++) begin
      tick("t2");
      if (e >= 2 && e <= 4) begin
        rd(32'h8, v); check_val($sformatf("t2_count_e%0d", e), v, 32'(5 - e));
      end
      if (e >= 5) check_val($sformatf("t2_irq_e%0d", e), {31'd0, irq}, 32'd1);
      if (e == 6) begin rd(32'h0, v); check_val("t2_ctrl_e6", v, 32'h8); end
    end
    wr("t2", 32'h0, 32'h8);
    check_val("t2_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET = 2: period 5
    do_reset("t3rst");
    wr("t3", 32'h4, 32'd2);
    wr("t3", 32'h0, 32'hB);
    for (int e = 1; e <= 15; e++) begin
      tick("t3");
      check_val($sformatf("t3_irq_e%0d", e), {31'd0, irq},
                {31'd0, (e == 4 || e == 9 || e == 14)});
      if (e == 7) begin rd(32'h8, v); check_val("t3_reload_e7", v, 32'd2); end
    end

    // Masked interrupt
    do_reset("t4rst");
    wr("t4", 32'h4, 32'd1);
    wr("t4", 32'h0, 32'h1);
    for (int e = 1; e <= 6; e++) begin
      tick("t4");
      check_val("t4_irq", {31'd0, irq}, 32'd0);
    end
    rd(32'h0, v); check_val("t4_ctrl", v, 32'd0);
    wr("t4", 32'h0, 32'h8);
    check_val("t4_irq_after", {31'd0, irq}, 32'd0);

    // Mid-count disable, PRESET change, re-enable
    do_reset("t5rst");
    wr("t5", 32'h4, 32'd10);
    wr("t5", 32'h0, 32'h9);
    for (int e = 1; e <= 4; e++) tick("t5");
    wr("t5", 32'h0, 32'h8);
    rd(32'h8, v); check_val("t5_count_e5", v, 32'd7);
    tick("t5"); tick("t5");
    wr("t5", 32'h4, 32'd4);
    rd(32'h8, v); check_val("t5_frozen", v, 32'd7);
    check_val("t5_noirq", {31'd0, irq}, 32'd0);
    wr("t5", 32'h0, 32'h9);
    tick("t5"); tick("t5");
    rd(32'h8, v); check_val("t5_restart", v, 32'd4);

    // Async reset mid-count, then PRESET = 0
    do_reset("t6rst");
    wr("t6", 32'h4, 32'd10);
    wr("t6", 32'h0, 32'h9);
    for (int e = 1; e <= 6; e++) tick("t6");
    rd(32'h8, v); check_val("t6_count6", v, 32'd6);
    do_reset("t6async");
    wr("t6", 32'h4, 32'd0);
    wr("t6", 32'h0, 32'h9);
    for (int e = 1; e <= 3; e++) begin
      tick("t6");
      check_val($sformatf("t6_p0_irq_e%0d", e), {31'd0, irq}, {31'd0, e == 3});
    end

    // Randomized traffic against the model
    do_reset("rnd_rst");
    for (int unsigned n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] a, d;
        a = BASE + 32'($urandom_range(0, 3) * 4);
        if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
        d = $urandom;
        if (a[3:2] == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
        if (a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
        wr("rnd", a - BASE, d);
      end else begin
        tick("rnd");
      end
      addr = $urandom;
      #1;
      check_val("rnd_any", rdata, model_read(addr));
      if ($urandom_range(0, 299) == 0) do_reset("rnd_async");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
